decode_stage_hs: RTL
====================

// Module: decode_stage_hs
// PURPOSE
//  Parametrised RV32I/RV32E decode stage, between Fetch and Execute. Adds a valid/ready handshake on both sides.
//  Adds a per-register write scoreboard with RAW interlock, plus a write-back bypass into the operands.
//  Adds illegal-instruction flagging and a configurable register count.
//  Decodes with the DECODE_*/CONTROL_* encodings of Definitions.vh.
//  Owns the architectural register file: NREGS entries, x0 reads zero.
// PARAMETERS
//  XLEN      32          datapath / PC width
//  NREGS     32          architectural registers (32 = RV32I, 16 = RV32E)
//  CTRL_W    13          control word width to Execute
//  BOOT_ADDR `BOOT_ADDR  exec_pc_o value on reset/flush
//  CNT_W     2           scoreboard counter width (max 2^CNT_W-1 writes in flight per register)
// PORTS
//  clk_i             in   1       clock
//  rst_i             in   1       reset, synchronous, active-high
//  ftch_valid_i      in   1       fetch payload valid
//  ftch_ready_o      out  1       decode accepts payload this cycle
//  ftch_instr_i      in   32      instruction word
//  ftch_pc_i         in   XLEN    instruction PC
//  exec_valid_o      out  1       output register holds a live instruction
//  exec_ready_i      in   1       Execute consumes exec_* this cycle
//  exec_flush_i      in   1       kill the instruction in the output register
//  exec_ctrl_signal_o out CTRL_W  control word
//  exec_operand1_o   out  XLEN    rs1 or PC
//  exec_operand2_o   out  XLEN    rs2 or immediate
//  exec_rs2_o        out  XLEN    rs2 value (store data / branch compare)
//  exec_rd_addr_o    out  5       destination register
//  exec_pc_o         out  XLEN    instruction PC
//  exec_illegal_o    out  1       instruction undecodable or register index >= NREGS
//  wb_rd_addr_i      in   5       write-back address
//  wb_rd_i           in   XLEN    write-back data
//  wb_rd_en_i        in   1       write-back enable
// BEHAVIOUR
//  - Reset (sync, rst_i high at posedge):
//    - exec_valid_o=0, exec_illegal_o=0.
//    - ctrl = NOP-to-execute encoding; exec_pc_o=BOOT_ADDR.
//    - All other exec_* = 0; all scoreboard counters = 0.
//    - ftch_ready_o=0 while rst_i high.
//  - Register usage:
//    - rs1 is used unless LUI/AUIPC/JAL. rs2 is used by R/S/B.
//    - Writes rd if rd!=0 and not S/B, and only if not illegal.
//  - hazard = a used rs (nonzero) has cnt[rs]!=0, unless cnt[rs]==1 and wb_rd_en_i && wb_rd_addr_i==rs.
//    In the bypass case the operand takes wb_rd_i.
//  - ftch_ready_o = !rst_i && !exec_flush_i && !hazard && (!exec_valid_o || exec_ready_i).
//  - Accept = ftch_valid_i && ftch_ready_o. Latency 1 cycle: at next posedge exec_* loads decoded payload, exec_valid_o=1.
//  - Consume without accept: exec_valid_o=0, payload regs hold. Neither: all exec_* hold stable.
//  - Scoreboard updates per posedge, applied together:
//    - +1 on cnt[rd] when an accepted instr writes rd.
//    - -1 on cnt[wb_rd_addr_i] when wb_rd_en_i and addr!=0.
//    - -1 on cnt[exec_rd_addr_o] when exec_flush_i kills a live rd-writing instr.
//    - Same-register +1/-1 nets to 0. Counters saturate at 0 and at max; either is a sim assertion error.
//  - Flush: beats exec_ready_i.
//    - exec_valid_o=0, ctrl=NOP, exec_pc_o=BOOT_ADDR next cycle.
//    - Fetch side is not accepted that cycle.
//  - Illegal (no decode match, or any rs/rd index >= NREGS):
//    - Passes with ctrl=CONTROL_NOP, exec_illegal_o=1.
//    - No scoreboard increment; never stalls.
//  - Register file: written at posedge on wb_rd_en_i (addr!=0, <NREGS); read combinationally from ftch_instr_i.
//  - Immediates: I/S/B/U/J sign rules per RV32I.
// TESTING
//  1 addi x1,x0,5 ; add x2,x1,x1 back-to-back
//    -> add stalls (ftch_ready_o=0) until WB of x1; issues on WB cycle with operand1=operand2=5.
//  2 exec_ready_i low 3 cycles with exec_valid_o=1
//    -> exec_* bit-stable, ftch_ready_o=0, next instr issued exactly once.
//  3 lw x5 in output reg, exec_flush_i=1
//    -> exec_valid_o=0, cnt[x5]=0; next add x6,x5,x0 issues without stall.
//  4 NREGS=16, add x17,x1,x2 -> exec_illegal_o=1, ctrl=CONTROL_NOP, no counter change.
//  5 addi x0,x0,1 ; add x3,x0,x0 -> no stall, operands 0.
//  6 rst_i mid-stall -> reset values next cycle, counters 0, ftch_ready_o=1 first cycle after rst_i low.

Source files
------------

// File: rtl/decode_stage_hs.sv
// decode_stage_hs
//   RV32I / RV32E decode stage between Fetch and Execute.
//   - valid/ready handshake on both sides, one output register stage
//   - architectural register file (x0 reads zero), combinational read,
//     written by the write-back port
//   - per-register in-flight write counters with RAW interlock and a
//     write-back bypass into the operands
//   - illegal instruction / out-of-range register flagging
// Ports
//   clk_i, rst_i                          clock, synchronous active-high reset
//   ftch_valid_i/ftch_ready_o             fetch handshake
//   ftch_instr_i, ftch_pc_i               fetch payload
//   exec_valid_o/exec_ready_i             execute handshake
//   exec_flush_i                          kill the instruction in the output register
//   exec_ctrl_signal_o .. exec_illegal_o  decoded payload
//   wb_rd_addr_i, wb_rd_i, wb_rd_en_i     write-back port
// Control word layout (low 13 bits, upper bits zero):
//   [3:0] alu_op  [4] op1_is_pc  [5] op2_is_imm  [6] mem_read  [7] mem_write
//   [8] branch    [9] jump       [10] reg_write  [12:11] wb_sel (0 alu,1 mem,2 pc+4)
//   For loads, stores and branches alu_op carries {1'b0, funct3}.
`ifndef BOOT_ADDR
`define BOOT_ADDR 32'h0000_0000
`endif

module decode_stage_hs #(
    parameter int              XLEN      = 32,
    parameter int              NREGS     = 32,
    parameter int              CTRL_W    = 13,
    parameter logic [XLEN-1:0] BOOT_ADDR = `BOOT_ADDR,
    parameter int              CNT_W     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ftch_valid_i,
    output logic              ftch_ready_o,
    input  logic [31:0]       ftch_instr_i,
    input  logic [XLEN-1:0]   ftch_pc_i,
    output logic              exec_valid_o,
    input  logic              exec_ready_i,
    input  logic              exec_flush_i,
    output logic [CTRL_W-1:0] exec_ctrl_signal_o,
    output logic [XLEN-1:0]   exec_operand1_o,
    output logic [XLEN-1:0]   exec_operand2_o,
    output logic [XLEN-1:0]   exec_rs2_o,
    output logic [4:0]        exec_rd_addr_o,
    output logic [XLEN-1:0]   exec_pc_o,
    output logic              exec_illegal_o,
    input  logic [4:0]        wb_rd_addr_i,
    input  logic [XLEN-1:0]   wb_rd_i,
    input  logic              wb_rd_en_i
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;
    localparam logic [12:0]      CONTROL_NOP = 13'h0000;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    // ---------------- field extraction / decode ----------------
    logic [6:0] w_opcode, w_f7;
    logic [2:0] w_f3;
    logic [4:0] w_rd, w_rs1, w_rs2;
    assign w_opcode = ftch_instr_i[6:0];
    assign w_f3     = ftch_instr_i[14:12];
    assign w_f7     = ftch_instr_i[31:25];
    assign w_rd     = ftch_instr_i[11:7];
    assign w_rs1    = ftch_instr_i[19:15];
    assign w_rs2    = ftch_instr_i[24:20];

    logic            w_legal, w_use_rs1, w_use_rs2, w_has_rd, w_op1_pc, w_op1_zero, w_op2_imm;
    logic            w_mem_rd, w_mem_wr, w_branch, w_jump;
    logic [1:0]      w_wb_sel;
    logic [3:0]      w_alu;
    logic [XLEN-1:0] w_imm;

    always_comb begin
        w_legal = 1'b0; w_use_rs1 = 1'b0; w_use_rs2 = 1'b0; w_has_rd = 1'b0;
        w_op1_pc = 1'b0; w_op1_zero = 1'b0; w_op2_imm = 1'b1;
        w_mem_rd = 1'b0; w_mem_wr = 1'b0; w_branch = 1'b0; w_jump = 1'b0;
        w_wb_sel = 2'd0; w_alu = ALU_ADD; w_imm = '0;
        case (w_opcode)
            OP_LUI: begin
                w_legal = 1'b1; w_has_rd = 1'b1; w_op1_zero = 1'b1;
                w_imm = {{(XLEN-32){ftch_instr_i[31]}}, ftch_instr_i[31:12], 12'b0};
            end
            OP_AUIPC: begin
                w_legal = 1'b1; w_has_rd = 1'b1; w_op1_pc = 1'b1;
                w_imm = {{(XLEN-32){ftch_instr_i[31]}}, ftch_instr_i[31:12], 12'b0};
            end
            OP_JAL: begin
                w_legal = 1'b1; w_has_rd = 1'b1; w_op1_pc = 1'b1; w_jump = 1'b1; w_wb_sel = 2'd2;
                w_imm = {{(XLEN-20){ftch_instr_i[31]}}, ftch_instr_i[19:12], ftch_instr_i[20],
                         ftch_instr_i[30:21], 1'b0};
            end
            OP_JALR: begin
                w_legal = (w_f3 == 3'b000); w_use_rs1 = 1'b1; w_has_rd = 1'b1;
                w_jump = 1'b1; w_wb_sel = 2'd2;
                w_imm = {{(XLEN-12){ftch_instr_i[31]}}, ftch_instr_i[31:20]};
            end
            OP_BRANCH: begin
                // rs1 in operand1, rs2 on exec_rs2_o, offset in operand2
                w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_branch = 1'b1; w_alu = {1'b0, w_f3};
                w_imm = {{(XLEN-12){ftch_instr_i[31]}}, ftch_instr_i[7], ftch_instr_i[30:25],
                         ftch_instr_i[11:8], 1'b0};
            end
            OP_LOAD: begin
                w_legal = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
                w_use_rs1 = 1'b1; w_has_rd = 1'b1; w_mem_rd = 1'b1; w_wb_sel = 2'd1;
                w_alu = {1'b0, w_f3};
                w_imm = {{(XLEN-12){ftch_instr_i[31]}}, ftch_instr_i[31:20]};
            end
            OP_STORE: begin
                w_legal = (w_f3 <= 3'b010); w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_mem_wr = 1'b1; w_alu = {1'b0, w_f3};
                w_imm = {{(XLEN-12){ftch_instr_i[31]}}, ftch_instr_i[31:25], ftch_instr_i[11:7]};
            end
            OP_IMM, OP_REG: begin
                w_use_rs1 = 1'b1; w_has_rd = 1'b1;
                w_use_rs2 = (w_opcode == OP_REG); w_op2_imm = (w_opcode == OP_IMM);
                w_imm = {{(XLEN-12){ftch_instr_i[31]}}, ftch_instr_i[31:20]};
                case (w_f3)
                    3'b000: w_alu = (w_opcode == OP_REG && w_f7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001: w_alu = ALU_SLL;
                    3'b010: w_alu = ALU_SLT;
                    3'b011: w_alu = ALU_SLTU;
                    3'b100: w_alu = ALU_XOR;
                    3'b101: w_alu = w_f7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: w_alu = ALU_OR;
                    default: w_alu = ALU_AND;
                endcase
                // funct7 only matters for shifts (both forms) and add/sub (register form)
                if (w_f3 == 3'b001)
                    w_legal = (w_f7 == 7'b0000000);
                else if (w_f3 == 3'b101 || (w_f3 == 3'b000 && w_opcode == OP_REG))
                    w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                else
                    w_legal = (w_opcode == OP_IMM) || (w_f7 == 7'b0000000);
            end
            default: w_legal = 1'b0;
        endcase
    end

    logic w_illegal, w_writes_rd;
    assign w_illegal = !w_legal || (w_use_rs1 && int'(w_rs1) >= NREGS)
                                || (w_use_rs2 && int'(w_rs2) >= NREGS)
                                || (w_has_rd && int'(w_rd) >= NREGS);
    assign w_writes_rd = w_has_rd && (w_rd != 5'd0) && !w_illegal;

    // ---------------- register file, scoreboard read, hazard ----------------
    logic [XLEN-1:0]  r_rf  [NREGS];
    logic [CNT_W-1:0] r_cnt [NREGS];
    logic [XLEN-1:0]  w_rf_rs1, w_rf_rs2;
    logic [CNT_W-1:0] w_cnt_rs1, w_cnt_rs2;

    always_comb begin
        w_rf_rs1 = '0; w_rf_rs2 = '0; w_cnt_rs1 = '0; w_cnt_rs2 = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (w_rs1 == 5'(i)) begin w_rf_rs1 = r_rf[i]; w_cnt_rs1 = r_cnt[i]; end
            if (w_rs2 == 5'(i)) begin w_rf_rs2 = r_rf[i]; w_cnt_rs2 = r_cnt[i]; end
        end
    end

    logic            w_byp1, w_byp2, w_haz1, w_haz2, w_hazard, w_accept;
    logic [XLEN-1:0] w_rs1_val, w_rs2_val;
    assign w_byp1    = wb_rd_en_i && (wb_rd_addr_i == w_rs1) && (w_rs1 != 5'd0);
    assign w_byp2    = wb_rd_en_i && (wb_rd_addr_i == w_rs2) && (w_rs2 != 5'd0);
    assign w_rs1_val = w_byp1 ? wb_rd_i : w_rf_rs1;
    assign w_rs2_val = w_byp2 ? wb_rd_i : w_rf_rs2;
    // A single outstanding write that lands this very cycle is bypassed, not stalled on.
    assign w_haz1 = w_use_rs1 && (w_rs1 != 5'd0) && (w_cnt_rs1 != '0)
                    && !((w_cnt_rs1 == CNT_W'(1)) && w_byp1);
    assign w_haz2 = w_use_rs2 && (w_rs2 != 5'd0) && (w_cnt_rs2 != '0)
                    && !((w_cnt_rs2 == CNT_W'(1)) && w_byp2);
    assign w_hazard = !w_illegal && (w_haz1 || w_haz2);

    assign ftch_ready_o = !rst_i && !exec_flush_i && !w_hazard && (!exec_valid_o || exec_ready_i);
    assign w_accept     = ftch_valid_i && ftch_ready_o;

    always_ff @(posedge clk_i) begin
        for (int i = 1; i < NREGS; i++)
            if (wb_rd_en_i && wb_rd_addr_i == 5'(i)) r_rf[i] <= wb_rd_i;
    end

    // ---------------- scoreboard counters ----------------
    // Offset-by-2 sum keeps the -2..+1 net update unsigned.
    logic [CNT_W-1:0] w_cnt_next [NREGS];
    logic [NREGS-1:0] w_under, w_over;
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_cnt
            logic             w_inc, w_dec_wb, w_dec_fl;
            logic [CNT_W+1:0] w_sum;
            assign w_inc    = w_accept && w_writes_rd && (w_rd == 5'(gi));
            assign w_dec_wb = (gi != 0) && wb_rd_en_i && (wb_rd_addr_i == 5'(gi));
            assign w_dec_fl = (gi != 0) && exec_flush_i && exec_valid_o && (exec_rd_addr_o == 5'(gi));
            assign w_sum    = {2'b00, r_cnt[gi]} + (CNT_W+2)'(w_inc) + (CNT_W+2)'(2)
                              - (CNT_W+2)'(w_dec_wb) - (CNT_W+2)'(w_dec_fl);
            assign w_under[gi] = (w_sum < (CNT_W+2)'(2));
            assign w_over[gi]  = (w_sum > ({2'b00, CNT_MAX} + (CNT_W+2)'(2)));
            assign w_cnt_next[gi] = w_under[gi] ? '0 : w_over[gi] ? CNT_MAX
                                  : CNT_W'(w_sum - (CNT_W+2)'(2));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) r_cnt[i] <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            assert (w_under == '0 && w_over == '0)
                else $error("decode_stage_hs: scoreboard counter saturated (under=%h over=%h)",
                            w_under, w_over);
        end
    end

    // ---------------- output register ----------------
    logic [12:0] w_ctrl;
    assign w_ctrl = w_illegal ? CONTROL_NOP
                  : {w_wb_sel, w_writes_rd, w_jump, w_branch, w_mem_wr, w_mem_rd,
                     w_op2_imm, w_op1_pc, w_alu};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exec_valid_o       <= 1'b0;
            exec_illegal_o     <= 1'b0;
            exec_ctrl_signal_o <= CTRL_W'(CONTROL_NOP);
            exec_pc_o          <= BOOT_ADDR;
            exec_operand1_o    <= '0;
            exec_operand2_o    <= '0;
            exec_rs2_o         <= '0;
            exec_rd_addr_o     <= '0;
        end else if (exec_flush_i) begin
            exec_valid_o       <= 1'b0;
            exec_illegal_o     <= 1'b0;
            exec_ctrl_signal_o <= CTRL_W'(CONTROL_NOP);
            exec_pc_o          <= BOOT_ADDR;
            exec_rd_addr_o     <= '0;
        end else if (w_accept) begin
            exec_valid_o       <= 1'b1;
            exec_illegal_o     <= w_illegal;
            exec_ctrl_signal_o <= CTRL_W'(w_ctrl);
            exec_pc_o          <= ftch_pc_i;
            exec_operand1_o    <= w_op1_pc ? ftch_pc_i : (w_op1_zero ? '0 : w_rs1_val);
            exec_operand2_o    <= w_op2_imm ? w_imm : w_rs2_val;
            exec_rs2_o         <= w_use_rs2 ? w_rs2_val : '0;
            exec_rd_addr_o     <= w_writes_rd ? w_rd : 5'd0;
        end else if (exec_ready_i) begin
            exec_valid_o <= 1'b0;
        end
    end
endmodule
